fetch_predictor: RTL and testbench

Parametrised front-end for the next-generation pipelined RV32I core. It replaces the fixed PC+4/PCSrc PC register with a fetch PC unit that predicts branches and jumps at fetch time. Prediction uses a direct-mapped BTB and a 2-bit saturating-counter BHT. Execute-stage resolution updates the predictor and, on a mispredict, redirects fetch.

---
 rtl/fetch_pkg.sv | 44 ++++
 rtl/bht_table.sv | 41 ++++
 rtl/fetch_predictor.sv | 147 ++++++++++++++
 tb/tb_fetch_predictor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and width helpers for the fetch predictor.
//   bht_cnt_t   : 2-bit saturating branch-history counter
//   btb_entry_t : one direct-mapped BTB entry (tag/target sized for PKG_XLEN)
package fetch_pkg;

    // Storage width for BTB tag/target fields; the top's XLEN must not exceed it.
    localparam int unsigned PKG_XLEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bht_cnt_t;

    typedef struct packed {
        logic                valid;
        logic [PKG_XLEN-1:0] tag;
        logic [PKG_XLEN-1:0] target;
        logic                is_jump;
    } btb_entry_t;

    // Index width of a table with the given (power-of-2) entry count.
    function automatic int unsigned idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

    // Tag width: everything above the index and the two word-offset bits.
    function automatic int unsigned tag_w(input int unsigned xlen, input int unsigned entries);
        return xlen - idx_w(entries) - 2;
    endfunction

    // Saturating counter step towards the resolved direction.
    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        case (cnt)
            SNT:     return taken ? WNT : SNT;
            WNT:     return taken ? WT  : SNT;
            WT:      return taken ? ST  : WNT;
            ST:      return taken ? ST  : WT;
            default: return WNT;
        endcase
    endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: array of 2-bit saturating counters.
//   clk_i, rst_ni        : clock, async active-low reset (counters -> WNT)
//   rd_idx_i, rd_cnt_c_o : combinational read port
//   upd_en_i, upd_idx_i,
//   upd_taken_i          : saturating increment/decrement at the clock edge
module bht_table
    import fetch_pkg::*;
#(
    parameter  int unsigned ENTRIES = 64,
    localparam int unsigned IDX_W   = idx_w(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    output bht_cnt_t         rd_cnt_c_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    bht_cnt_t cnt_q [ENTRIES];
    bht_cnt_t cnt_d;

    // Read returns the pre-update value when read and write hit the same entry.
    assign rd_cnt_c_o = cnt_q[rd_idx_i];

    always_comb begin
        cnt_d = bht_next(cnt_q[upd_idx_i], upd_taken_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_q[IDX_W'(i)] <= WNT;
            end
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_predictor.sv
// Fetch PC unit with BTB + BHT branch prediction and EX-stage redirect.
//   clk, rst (async active-low)
//   stall                       : hold PC unless a redirect is pending
//   upd_*                       : resolved control-flow info from EX
//   pc, pc_plus4                : current fetch PC and its sequential successor
//   pred_taken, pred_target     : combinational prediction for pc
//   flush                       : registered, one cycle after each redirect
//   perf_branches/mispredicts   : saturating event counters
module fetch_predictor
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BHT_ENTRIES = 64,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              upd_mispredict,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    output logic              flush,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int unsigned BHT_IDX_W = idx_w(BHT_ENTRIES);
    localparam int unsigned BTB_IDX_W = idx_w(BTB_ENTRIES);
    localparam int unsigned TAG_W     = tag_w(XLEN, BTB_ENTRIES);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic              flush_q, flush_d;
    logic [PERF_W-1:0] perf_br_q, perf_br_d;
    logic [PERF_W-1:0] perf_mp_q, perf_mp_d;
    btb_entry_t        btb_q [BTB_ENTRIES];

    // Lookup side, driven from the registered PC
    logic [BTB_IDX_W-1:0] btb_rd_idx;
    logic [PKG_XLEN-1:0]  btb_rd_tag;
    btb_entry_t           btb_rd;
    logic                 btb_hit;
    bht_cnt_t             bht_rd_cnt;
    logic                 bht_pred_taken;

    // Update side
    logic [BTB_IDX_W-1:0] btb_wr_idx;
    logic [PKG_XLEN-1:0]  btb_wr_tag;
    logic                 redirect;
    logic [XLEN-1:0]      redirect_pc;

    assign btb_rd_idx = pc_q[BTB_IDX_W+1:2];
    assign btb_rd_tag = PKG_XLEN'(pc_q[XLEN-1 -: TAG_W]);
    assign btb_rd     = btb_q[btb_rd_idx];
    assign btb_hit    = btb_rd.valid && (btb_rd.tag == btb_rd_tag);

    bht_table #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk_i       (clk),
        .rst_ni      (rst),
        .rd_idx_i    (pc_q[BHT_IDX_W+1:2]),
        .rd_cnt_c_o  (bht_rd_cnt),
        .upd_en_i    (upd_valid && !upd_is_jump),
        .upd_idx_i   (upd_pc[BHT_IDX_W+1:2]),
        .upd_taken_i (upd_taken)
    );

    assign bht_pred_taken = (bht_rd_cnt == WT) || (bht_rd_cnt == ST);

    assign pc_plus4    = pc_q + XLEN'(4);
    assign pred_taken  = btb_hit && (btb_rd.is_jump || bht_pred_taken);
    assign pred_target = btb_hit ? XLEN'(btb_rd.target) : pc_plus4;

    assign redirect    = upd_valid && upd_mispredict;
    assign redirect_pc = upd_taken ? upd_target : (upd_pc + XLEN'(4));

    // Next-PC select: EX redirect beats stall beats prediction
    always_comb begin
        pc_d = pc_plus4;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // Flush and saturating performance counters
    always_comb begin
        flush_d   = redirect;
        perf_br_d = perf_br_q;
        perf_mp_d = perf_mp_q;
        if (upd_valid && (perf_br_q != '1)) begin
            perf_br_d = perf_br_q + PERF_W'(1);
        end
        if (redirect && (perf_mp_q != '1)) begin
            perf_mp_d = perf_mp_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            flush_q   <= 1'b0;
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            pc_q      <= pc_d;
            flush_q   <= flush_d;
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    assign btb_wr_idx = upd_pc[BTB_IDX_W+1:2];
    assign btb_wr_tag = PKG_XLEN'(upd_pc[XLEN-1 -: TAG_W]);

    // BTB allocate/replace on every taken resolution; not-taken leaves it alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[BTB_IDX_W'(i)] <= '0;
            end
        end else if (upd_valid && upd_taken) begin
            btb_q[btb_wr_idx] <= '{valid:   1'b1,
                                   tag:     btb_wr_tag,
                                   target:  PKG_XLEN'(upd_target),
                                   is_jump: upd_is_jump};
        end
    end

    assign pc               = pc_q;
    assign flush            = flush_q;
    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;

endmodule

// File: tb/tb_fetch_predictor.sv
// Directed, table-driven bench for fetch_predictor (RESET_PC=0x100, PERF_W=4).
module tb_fetch_predictor;

    localparam int unsigned PERF_W   = 4;
    localparam int          PERF_MAX = 15;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic              upd_is_jump;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_mispredict;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              flush;
    logic [PERF_W-1:0] perf_branches;
    logic [PERF_W-1:0] perf_mispredicts;

    fetch_predictor #(
        .XLEN        (32),
        .BHT_ENTRIES (64),
        .BTB_ENTRIES (16),
        .RESET_PC    (32'h0000_0100),
        .PERF_W      (PERF_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_is_jump      (upd_is_jump),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .flush            (flush),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        uv;
        logic [31:0] upc;
        logic        jmp;
        logic        tk;
        logic [31:0] tgt;
        logic        mp;
        logic [31:0] e_pc;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_fl;
    } vec_t;

    int n_err = 0;
    int n_chk = 0;
    int exp_br = 0;
    int exp_mp = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic uv, input logic [31:0] upc,
                                input logic jmp, input logic tk, input logic [31:0] tgt,
                                input logic mp, input logic [31:0] epc, input logic ept,
                                input logic [31:0] eptgt, input logic efl);
        vec_t v;
        v.st = st; v.uv = uv; v.upc = upc; v.jmp = jmp; v.tk = tk; v.tgt = tgt; v.mp = mp;
        v.e_pc = epc; v.e_pt = ept; v.e_ptgt = eptgt; v.e_fl = efl;
        return v;
    endfunction

    function automatic vec_t mk_idle(input logic st, input logic [31:0] epc, input logic ept,
                                     input logic [31:0] eptgt);
        return mk(st, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, epc, ept, eptgt, 1'b0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        stall = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    endtask

    // Reference perf-counter behaviour for the inputs currently being driven
    task automatic model_upd();
        if (upd_valid) begin
            if (exp_br < PERF_MAX) exp_br++;
            if (upd_mispredict && exp_mp < PERF_MAX) exp_mp++;
        end
    endtask

    task automatic chk_perf(input string nm);
        chk($sformatf("%s perf_branches", nm), 32'(perf_branches), 32'(exp_br));
        chk($sformatf("%s perf_mispredicts", nm), 32'(perf_mispredicts), 32'(exp_mp));
    endtask

    task automatic apply(input vec_t v, input string nm);
        stall = v.st; upd_valid = v.uv; upd_pc = v.upc; upd_is_jump = v.jmp;
        upd_taken = v.tk; upd_target = v.tgt; upd_mispredict = v.mp;
        model_upd();
        tick();
        chk($sformatf("%s pc", nm), pc, v.e_pc);
        chk($sformatf("%s pred_taken", nm), 32'(pred_taken), 32'(v.e_pt));
        chk($sformatf("%s pred_target", nm), pred_target, v.e_ptgt);
        chk($sformatf("%s flush", nm), 32'(flush), 32'(v.e_fl));
        chk_perf(nm);
    endtask

    // Update only, pc not tracked; used for counter saturation
    task automatic upd_only(input logic mp, input string nm);
        set_idle();
        upd_valid = 1'b1; upd_pc = 32'h400; upd_mispredict = mp;
        model_upd();
        tick();
        chk_perf(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        set_idle();
        rst = 1'b0;

        // Reset held for three cycles
        repeat (3) tick();
        chk("reset pc", pc, 32'h100);
        chk("reset pred_taken", 32'(pred_taken), 32'h0);
        chk("reset flush", 32'(flush), 32'h0);
        chk_perf("reset");
        rst = 1'b1;
        chk("release pc", pc, 32'h100);

        // stall, uv, upd_pc, jmp, tk, target, mp | pc, pred_taken, pred_target, flush
        tbl.push_back(mk_idle(0, 32'h104, 0, 32'h108));
        tbl.push_back(mk_idle(0, 32'h108, 0, 32'h10C));
        // loop branch at 0x20 -> 0x10 learned over two mispredicts
        tbl.push_back(mk(0, 1, 32'h20, 0, 1, 32'h10, 1, 32'h10, 0, 32'h14, 1));
        tbl.push_back(mk_idle(0, 32'h14, 0, 32'h18));
        tbl.push_back(mk(0, 1, 32'h20, 0, 1, 32'h10, 1, 32'h10, 0, 32'h14, 1));
        tbl.push_back(mk_idle(0, 32'h14, 0, 32'h18));
        tbl.push_back(mk_idle(0, 32'h18, 0, 32'h1C));
        tbl.push_back(mk_idle(0, 32'h1C, 0, 32'h20));
        tbl.push_back(mk_idle(0, 32'h20, 1, 32'h10));
        tbl.push_back(mk_idle(0, 32'h10, 0, 32'h14));
        // not-taken from ST: redirect to 0x24, counter now WT, still predicts taken
        tbl.push_back(mk(0, 1, 32'h20, 0, 0, 32'h10, 1, 32'h24, 0, 32'h28, 1));
        tbl.push_back(mk(0, 1, 32'h1C, 0, 0, 32'h0, 1, 32'h20, 1, 32'h10, 1));
        tbl.push_back(mk_idle(0, 32'h10, 0, 32'h14));
        // JAL 0x40 -> 0x200 predicts taken with a weak counter
        tbl.push_back(mk(0, 1, 32'h40, 1, 1, 32'h200, 1, 32'h200, 0, 32'h204, 1));
        tbl.push_back(mk(0, 1, 32'h3C, 0, 0, 32'h0, 1, 32'h40, 1, 32'h200, 1));
        tbl.push_back(mk_idle(0, 32'h200, 0, 32'h204));
        // stall holds four cycles; redirect beats stall
        tbl.push_back(mk_idle(1, 32'h200, 0, 32'h204));
        tbl.push_back(mk_idle(1, 32'h200, 0, 32'h204));
        tbl.push_back(mk_idle(1, 32'h200, 0, 32'h204));
        tbl.push_back(mk_idle(1, 32'h200, 0, 32'h204));
        tbl.push_back(mk(1, 1, 32'h50, 0, 1, 32'h300, 1, 32'h300, 0, 32'h304, 1));
        tbl.push_back(mk_idle(1, 32'h300, 0, 32'h304));
        // counter at 0x40 still WNT after the jump: taken then not-taken leaves WNT
        tbl.push_back(mk(0, 1, 32'h40, 0, 1, 32'h200, 0, 32'h304, 0, 32'h308, 0));
        tbl.push_back(mk(0, 1, 32'h40, 0, 0, 32'h0, 0, 32'h308, 0, 32'h30C, 0));
        tbl.push_back(mk(0, 1, 32'h3C, 0, 0, 32'h0, 1, 32'h40, 0, 32'h200, 1));
        // aliasing 0x0 / 0x40 on BTB index 0
        tbl.push_back(mk(0, 1, 32'h0, 1, 1, 32'h80, 1, 32'h80, 0, 32'h84, 1));
        tbl.push_back(mk(0, 1, 32'h3C, 0, 0, 32'h0, 1, 32'h40, 0, 32'h44, 1));
        tbl.push_back(mk(0, 1, 32'h40, 1, 1, 32'h200, 1, 32'h200, 0, 32'h204, 1));
        // not-taken at 0xFFFFFFFC wraps redirect to 0x0; 0x0 misses after eviction
        tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 1, 32'h0, 0, 32'h4, 1));
        tbl.push_back(mk_idle(0, 32'h4, 0, 32'h8));
        // fetch at top of address space: pc_plus4 wraps to 0
        tbl.push_back(mk(0, 1, 32'h8, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 1));
        tbl.push_back(mk_idle(0, 32'h0, 0, 32'h4));

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // Perf counters saturate at 15 and never wrap
        for (int i = 0; i < 5; i++) upd_only(1'b0, $sformatf("sat_br%0d", i));
        for (int i = 0; i < 4; i++) upd_only(1'b1, $sformatf("sat_mp%0d", i));
        chk("sat final branches", 32'(perf_branches), 32'd15);
        chk("sat final mispredicts", 32'(perf_mispredicts), 32'd15);

        // Asynchronous reset with an update in flight
        set_idle();
        upd_valid = 1'b1; upd_pc = 32'h60; upd_taken = 1'b1;
        upd_target = 32'h500; upd_mispredict = 1'b1;
        #2 rst = 1'b0;
        #1;
        exp_br = 0;
        exp_mp = 0;
        chk("async rst pc", pc, 32'h100);
        chk("async rst flush", 32'(flush), 32'h0);
        chk("async rst pred_taken", 32'(pred_taken), 32'h0);
        chk_perf("async rst");
        set_idle();
        tick();
        rst = 1'b1;
        chk("rerelease pc", pc, 32'h100);
        chk("rerelease pred_taken", 32'(pred_taken), 32'h0);
        chk("rerelease flush", 32'(flush), 32'h0);
        apply(mk_idle(0, 32'h104, 0, 32'h108), "post_rst0");
        // BTB was cleared: 0x20 no longer predicts taken
        apply(mk(0, 1, 32'h1C, 0, 0, 32'h0, 1, 32'h20, 0, 32'h24, 1), "post_rst1");
        apply(mk_idle(0, 32'h24, 0, 32'h28), "post_rst2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
